score_comparator: RTL and testbench

Final-stage argmax block of the CNN digit-recognition pipeline. Consumes the OUTPUT_NUM signed class scores that the fully connected layer emits one per `valid_in` strobe (index 0 first). Tracks the running maximum and, after the last score of a frame, presents the winning class index and its score with a one-cycle `valid_out` pulse. Runs continuously frame after frame with no idle gap required between frames.

---
 rtl/score_comparator.sv | 60 ++++++
 tb/tb_score_comparator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/score_comparator.sv
// score_comparator: streaming argmax over OUTPUT_NUM signed class scores per frame,
// reporting the winning index and score with a one-cycle valid_out pulse.
module score_comparator #(
   parameter int OUTPUT_NUM = 10,
   parameter int DATA_BITS  = 12,
   parameter int IDX_BITS   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic signed [DATA_BITS-1:0] data_in,
   input  logic                        flush,
   output logic [IDX_BITS-1:0]         decision,
   output logic signed [DATA_BITS-1:0] max_score,
   output logic                        valid_out,
   output logic                        busy
);
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(OUTPUT_NUM - 1);
   state_t                      r_state, w_next;
   logic [IDX_BITS-1:0]         r_cnt, r_idx, w_idx;
   logic signed [DATA_BITS-1:0] r_max, w_max;
   logic                        w_take, w_last, w_upd;
   // The first score of a frame always loads, so stale run_max never competes.
   always_comb begin
      w_take = valid_in && !flush;
      w_last = r_cnt == LAST;
      w_upd  = (r_state == IDLE) || (data_in > r_max);
      w_max  = w_upd ? data_in : r_max;
      w_idx  = w_upd ? r_cnt : r_idx;
      w_next = flush ? IDLE : (w_take ? (w_last ? IDLE : ACCUM) : r_state);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_max     <= '0;
         decision  <= '0;
         max_score <= '0;
         valid_out <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_next;
         busy      <= w_next == ACCUM;
         valid_out <= w_take && w_last;
         if (flush) begin
            r_cnt <= '0;
         end else if (w_take) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_max <= w_max;
            r_idx <= w_idx;
            if (w_last) begin
               decision  <= w_idx;
               max_score <= w_max;
            end
         end
      end
   end
endmodule

// File: tb/tb_score_comparator.sv
// tb_score_comparator: directed test-plan frames plus randomized frames/gaps/flushes,
// checked every cycle against a queue-based argmax reference model.
module tb_score_comparator;
   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                valid_in = 1'b0;
   logic signed [11:0]  data_in = '0;
   logic                flush = 1'b0;
   logic [3:0]          decision;
   logic signed [11:0]  max_score;
   logic                valid_out, busy;
   int                  n_cmp = 0, n_err = 0;
   int                  q[$];
   int                  exp_dec = 0, exp_max = 0, exp_vo = 0, exp_busy = 0;

   score_comparator #(.OUTPUT_NUM(10), .DATA_BITS(12), .IDX_BITS(4)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .flush(flush),
      .decision(decision), .max_score(max_score), .valid_out(valid_out), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid_out"}, int'(valid_out), exp_vo);
      chk({tag, ".busy"}, int'(busy), exp_busy);
      chk({tag, ".decision"}, int'(decision), exp_dec);
      chk({tag, ".max_score"}, int'(max_score), exp_max);
   endtask

   // Model: a frame is just the list of accepted scores; winner is the first maximum.
   task automatic cycle(input string tag, input bit v, input int d, input bit f);
      int best;
      valid_in = v;
      data_in  = d[11:0];
      flush    = f;
      exp_vo   = 0;
      if (f) q.delete();
      else if (v) begin
         q.push_back(d);
         if (q.size() == 10) begin
            best = 0;
            for (int i = 1; i < 10; i++) if (q[i] > q[best]) best = i;
            exp_dec = best;
            exp_max = q[best];
            exp_vo  = 1;
            q.delete();
         end
      end
      exp_busy = q.size() > 0;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      flush    = 1'b0;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, 0, 1'b0);
   endtask

   task automatic send_frame(input string tag, input int s[10]);
      for (int i = 0; i < 10; i++) cycle(tag, 1'b1, s[i], 1'b0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      q.delete();
      exp_dec = 0; exp_max = 0; exp_vo = 0; exp_busy = 0;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int fa[10], fb[10];
      #1;
      do_reset("reset");

      send_frame("t1", '{5, -3, 100, 7, 0, 12, -50, 99, 1, 2});
      idle("t1_after", 2);

      send_frame("t2_neg", '{-20, -5, -9, -5, -100, -30, -7, -6, -8, -40});
      idle("t2_after", 1);

      for (int i = 0; i < 10; i++) begin
         cycle("t3_gap", 1'b1, i, 1'b0);
         idle("t3_gap_idle", $urandom_range(0, 5));
      end
      idle("t3_after", 1);

      for (int i = 0; i < 10; i++) begin
         fa[i] = (i == 4) ? 300 : int'($urandom_range(0, 599)) - 300;
         fb[i] = (i == 0) ? 2047 : int'($urandom_range(0, 4095)) - 2048;
      end
      send_frame("t4_a", fa);
      send_frame("t4_b", fb);
      idle("t4_after", 1);

      for (int i = 0; i < 6; i++) cycle("t5_part", 1'b1, 1000 + i, 1'b0);
      cycle("t5_flush", 1'b1, 2000, 1'b1);
      idle("t5_idle", 1);
      for (int i = 0; i < 10; i++) cycle("t5_frame", 1'b1, (i == 7) ? -1 : -2048, 1'b0);
      idle("t5_after", 1);

      for (int i = 0; i < 5; i++) cycle("t6_part", 1'b1, 500 + i, 1'b0);
      do_reset("t6_rst");
      send_frame("t6_frame", '{-1, 3, 8, 8, -7, 2, 1, 0, 5, 4});
      idle("t6_after", 1);

      for (int i = 0; i < 400; i++) begin
         bit v, f;
         v = $urandom_range(0, 3) != 0;
         f = $urandom_range(0, 29) == 0;
         cycle("rand", v, int'($urandom_range(0, 4095)) - 2048, f);
      end
      idle("rand_after", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
